// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage feeding the decoder.
// Issues in-order word reads, buffers responses in a small FIFO and
// flushes wrong-path fetches on J/JAL/JR redirects from the decoder.
// Optional feature macro: FETCH_PERF_CNT_EN (redirect / stall counters).
`ifndef WORD_BITS
`define WORD_BITS 32
`endif
`ifndef INST_BITS
`define INST_BITS 32
`endif

module inst_fetch #(
  parameter logic [`WORD_BITS-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [`WORD_BITS-1:0] o_imem_addr,
  output logic                  o_imem_req,
  input  logic                  i_imem_ack,
  input  logic [`INST_BITS-1:0] i_imem_rdata,
  input  logic                  i_imem_rvalid,
  output logic [`INST_BITS-1:0] o_inst,
  output logic                  o_inst_valid,
  output logic [`WORD_BITS-1:0] o_pc,
  input  logic                  i_stall,
  input  logic [`WORD_BITS-1:0] i_j_addr,
  input  logic                  i_j_addr_valid,
  input  logic [`WORD_BITS-1:0] i_jal_addr,
  input  logic                  i_jal_addr_valid,
  input  logic                  i_jr,
  input  logic [`WORD_BITS-1:0] i_jr_addr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           o_perf_redirects,
  output logic [31:0]           o_perf_stall_cycles
`endif
);
  localparam int W  = `WORD_BITS;
  localparam int IW = `INST_BITS;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_RESET, S_RUN, S_DRAIN} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   fetch_pc;
  logic [W-1:0]   aq_mem [FIFO_DEPTH];   // addresses of issued requests, in order
  logic [PW-1:0]  aq_wr, aq_rd;
  logic [CW-1:0]  outstanding;
  logic [W-1:0]   fq_pc   [FIFO_DEPTH];
  logic [IW-1:0]  fq_inst [FIFO_DEPTH];
  logic [PW-1:0]  fq_wr, fq_rd;
  logic [CW-1:0]  fq_cnt;
  logic [CW-1:0]  drop_cnt, drop_nxt;
  logic [CW:0]    in_use;
  logic           issue, resp, push, pop, redirect;
  logic [W-1:0]   target;

  // Head presentation, redirect detection and issue credit.
  always_comb begin
    o_inst_valid = (fq_cnt != '0);
    o_inst       = o_inst_valid ? fq_inst[fq_rd] : '0;
    o_pc         = o_inst_valid ? fq_pc[fq_rd]   : '0;
    redirect     = o_inst_valid && !i_stall && (i_jr || i_jal_addr_valid || i_j_addr_valid);
    pop          = o_inst_valid && !i_stall;
    in_use       = {1'b0, outstanding} + {1'b0, fq_cnt};
    // Gated by rst so the request is low throughout reset.
    o_imem_req   = rst && (in_use < DEPTH) && !redirect;
    o_imem_addr  = fetch_pc;
    issue        = o_imem_req && i_imem_ack;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp         = i_imem_rvalid && (outstanding != '0);
    push         = resp && (state != S_DRAIN);
  end

  // Redirect target: jr beats jal beats j.
  always_comb begin
    target = i_j_addr;
    if (i_jr)                  target = i_jr_addr;
    else if (i_jal_addr_valid) target = i_jal_addr;
  end

  // Stale-response count: on redirect, everything still in flight after this
  // cycle's response becomes wrong-path.
  always_comb begin
    drop_nxt = drop_cnt;
    if (redirect)                        drop_nxt = outstanding - CW'(resp);
    else if (resp && state == S_DRAIN)   drop_nxt = drop_cnt - CW'(1);
  end

  // FSM next state: DRAIN while stale responses remain.
  always_comb begin
    state_nxt = S_RUN;
    if (drop_nxt != '0) state_nxt = S_DRAIN;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_RESET;
    else      state <= state_nxt;
  end

  // Control registers: PC, pointers and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      aq_wr       <= '0;
      aq_rd       <= '0;
      outstanding <= '0;
      fq_wr       <= '0;
      fq_rd       <= '0;
      fq_cnt      <= '0;
      drop_cnt    <= '0;
    end else begin
      drop_cnt    <= drop_nxt;
      outstanding <= outstanding + CW'(issue) - CW'(resp);
      if (redirect)   fetch_pc <= target;
      else if (issue) fetch_pc <= fetch_pc + W'(1);
      if (issue) aq_wr <= aq_wr + PW'(1);
      if (resp)  aq_rd <= aq_rd + PW'(1);
      if (redirect) begin
        // Drops this cycle's push as well.
        fq_wr  <= '0;
        fq_rd  <= '0;
        fq_cnt <= '0;
      end else begin
        if (push) fq_wr <= fq_wr + PW'(1);
        if (pop)  fq_rd <= fq_rd + PW'(1);
        fq_cnt <= fq_cnt + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage arrays; contents are qualified by the pointers/counts above.
  always_ff @(posedge clk) begin
    if (issue) aq_mem[aq_wr] <= fetch_pc;
    if (push) begin
      fq_pc[fq_wr]   <= aq_mem[aq_rd];
      fq_inst[fq_wr] <= i_imem_rdata;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_perf_redirects    <= '0;
      o_perf_stall_cycles <= '0;
    end else begin
      if (redirect && (o_perf_redirects != '1))
        o_perf_redirects <= o_perf_redirects + 32'd1;
      if (o_inst_valid && i_stall && (o_perf_stall_cycles != '1))
        o_perf_stall_cycles <= o_perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scoreboard bench for inst_fetch.
`ifndef WORD_BITS
`define WORD_BITS 32
`endif
`ifndef INST_BITS
`define INST_BITS 32
`endif

module tb_inst_fetch;
  localparam int W  = `WORD_BITS;
  localparam int IW = `INST_BITS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q [$];

  // main DUT signals
  logic          rst, stall, j_valid, jal_valid, jr;
  logic [W-1:0]  j_addr, jal_addr, jr_addr;
  logic [W-1:0]  imem_addr, pc;
  logic          imem_req, inst_valid;
  logic [IW-1:0] inst, rdata;
  logic          rvalid;
  wire           ack = 1'b1;

  // second DUT (RESET_PC all-ones) signals
  logic          rst2;
  wire           stall2 = 1'b1;
  wire           zero1  = 1'b0;
  wire [W-1:0]   zerow  = '0;
  logic [W-1:0]  imem_addr2, pc2;
  logic          imem_req2, inst_valid2;
  logic [IW-1:0] inst2, rdata2;
  logic          rvalid2;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redir, perf_stall, perf_redir2, perf_stall2;
`endif

  inst_fetch #(.RESET_PC('0), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .rst(rst),
    .o_imem_addr(imem_addr), .o_imem_req(imem_req), .i_imem_ack(ack),
    .i_imem_rdata(rdata), .i_imem_rvalid(rvalid),
    .o_inst(inst), .o_inst_valid(inst_valid), .o_pc(pc), .i_stall(stall),
    .i_j_addr(j_addr), .i_j_addr_valid(j_valid),
    .i_jal_addr(jal_addr), .i_jal_addr_valid(jal_valid),
    .i_jr(jr), .i_jr_addr(jr_addr)
`ifdef FETCH_PERF_CNT_EN
    , .o_perf_redirects(perf_redir), .o_perf_stall_cycles(perf_stall)
`endif
  );

  inst_fetch #(.RESET_PC('1), .FIFO_DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst2),
    .o_imem_addr(imem_addr2), .o_imem_req(imem_req2), .i_imem_ack(ack),
    .i_imem_rdata(rdata2), .i_imem_rvalid(rvalid2),
    .o_inst(inst2), .o_inst_valid(inst_valid2), .o_pc(pc2), .i_stall(stall2),
    .i_j_addr(zerow), .i_j_addr_valid(zero1),
    .i_jal_addr(zerow), .i_jal_addr_valid(zero1),
    .i_jr(zero1), .i_jr_addr(zerow)
`ifdef FETCH_PERF_CNT_EN
    , .o_perf_redirects(perf_redir2), .o_perf_stall_cycles(perf_stall2)
`endif
  );

  // Instruction word stored at a given address.
  function automatic logic [IW-1:0] data_of(input logic [W-1:0] a);
    logic [IW-1:0] key;
    key = IW'(32'h5EED_0000);
    return IW'(a) ^ key;
  endfunction

  // Memory models: ack at once, respond one cycle later, reset with the DUT.
  always @(posedge clk) begin
    rvalid  <= rst && imem_req && ack;
    rdata   <= data_of(imem_addr);
    rvalid2 <= rst2 && imem_req2 && ack;
    rdata2  <= data_of(imem_addr2);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every instruction the decoder consumes is checked against the queue.
  always @(negedge clk) begin
    if (rst && inst_valid && !stall) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_extra: got pc %0h want nothing", pc);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", 64'(pc), 64'(e));
        chk("sb_inst", 64'(inst), 64'(data_of(e)));
      end
    end
  end

  task automatic clear_redir();
    j_valid = 0; jal_valid = 0; jr = 0;
    j_addr = '0; jal_addr = '0; jr_addr = '0;
  endtask

  // Let exactly one instruction be consumed; redirect inputs set beforehand apply to it.
  task automatic take(input logic [W-1:0] e);
    bit seen;
    exp_q.push_back(e);
    @(posedge clk); #1 stall = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (inst_valid) seen = 1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL take_timeout: got no valid want pc %0h", e);
      void'(exp_q.pop_back());
    end
    @(posedge clk); #1 stall = 1;
    clear_redir();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; rst2 = 0; stall = 1;
    clear_redir();
    repeat (3) @(posedge clk);

    // Reset state
    @(negedge clk);
    chk("rst_valid", 64'(inst_valid), 64'(0));
    chk("rst_req",   64'(imem_req),   64'(0));
    chk("rst_pc",    64'(pc),         64'(0));
    chk("rst_inst",  64'(inst),       64'(0));

    // Release: first request immediately, instruction valid two cycles later
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("rel_req",  64'(imem_req),  64'(1));
    chk("rel_addr", 64'(imem_addr), 64'(0));
    @(negedge clk);
    chk("rel_valid_c1", 64'(inst_valid), 64'(0));
    @(negedge clk);
    chk("rel_valid_c2", 64'(inst_valid), 64'(1));
    chk("rel_pc",       64'(pc),         64'(0));
    for (int i = 0; i < 4; i++) take(W'(i));

    // J at pc 4 -> 0x20; pcs 5 and 6 must never appear
    j_addr = W'(32'h20); j_valid = 1;
    take(W'(4));
    take(W'(32'h20));

    // Stall 5 cycles: buffer full, request low, head held
    repeat (5) @(negedge clk);
    chk("stall_req",   64'(imem_req),   64'(0));
    chk("stall_valid", 64'(inst_valid), 64'(1));
    chk("stall_pc",    64'(pc),         64'(32'h21));
    chk("stall_inst",  64'(inst),       64'(data_of(W'(32'h21))));
    take(W'(32'h21)); take(W'(32'h22)); take(W'(32'h23));

    // JR and JAL together: JR wins
    jr = 1; jr_addr = W'(32'h40); jal_valid = 1; jal_addr = W'(32'h80);
    take(W'(32'h24));
    take(W'(32'h40));
    take(W'(32'h41));

    // Jump held under stall for 3 cycles is ignored, taken once when unstalled
    @(posedge clk); #1 j_addr = W'(32'h60); j_valid = 1;
    repeat (3) @(negedge clk);
    chk("stj_valid", 64'(inst_valid), 64'(1));
    chk("stj_pc",    64'(pc),         64'(32'h42));
    take(W'(32'h42));
    take(W'(32'h60));
    take(W'(32'h61));
    chk("sb_leftover", 64'(exp_q.size()), 64'(0));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_redirects", 64'(perf_redir), 64'(3));
`endif

    // RESET_PC all-ones: address wrap, then reset with work in flight
    @(posedge clk); #1 rst2 = 1;
    @(negedge clk);
    chk("wrap_req0",  64'(imem_req2),  64'(1));
    chk("wrap_addr0", 64'(imem_addr2), 64'(W'('1)));
    @(negedge clk);
    chk("wrap_req1",  64'(imem_req2),  64'(1));
    chk("wrap_addr1", 64'(imem_addr2), 64'(0));
    @(posedge clk); #1 rst2 = 0;
    @(negedge clk);
    chk("pre_rst_valid", 64'(inst_valid2), 64'(1));
    chk("pre_rst_pc",    64'(pc2),         64'(W'('1)));
    @(negedge clk);
    chk("mid_rst_valid", 64'(inst_valid2), 64'(0));
    chk("mid_rst_pc",    64'(pc2),         64'(0));
    chk("mid_rst_inst",  64'(inst2),       64'(0));
    chk("mid_rst_req",   64'(imem_req2),   64'(0));
    @(posedge clk); #1 rst2 = 1;
    @(negedge clk);
    chk("rerel_addr", 64'(imem_addr2), 64'(W'('1)));
    repeat (2) @(negedge clk);
    chk("rerel_valid", 64'(inst_valid2), 64'(1));
    chk("rerel_pc",    64'(pc2),         64'(W'('1)));
    chk("rerel_inst",  64'(inst2),       64'(data_of(W'('1))));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
